pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
Consumer end of the line-drawing pixel stream. Accepts one-cycle plot strobes with x/y coordinates from the line generator at up to one pixel per clock, and buffers them in a small FIFO. Clips off-screen pixels, converts x/y to a linear framebuffer address, and issues writes on a stalling memory port. Also provides a full-frame clear sweep; no backpressure is offered upstream, so losses are flagged.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines
ADDR_W, 19, framebuffer address width (must hold H_RES*V_RES-1)
COLOR_W, 4, pixel colour width
DEPTH, 8, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
plot  in  1  one-cycle pixel strobe
x  in  11  pixel column, unsigned
y  in  11  pixel row, unsigned
color  in  COLOR_W  pixel colour, sampled with plot
clear_req  in  1  one-cycle request to fill the frame with clear_color
clear_color  in  COLOR_W  fill colour, sampled with clear_req
ovf_clr  in  1  clears overflow flag
mem_we  out  1  write request valid
mem_addr  out  ADDR_W  write address
mem_wdata  out  COLOR_W  write data
mem_ready  in  1  memory accepts write when mem_we && mem_ready
busy  out  1  FIFO non-empty, mem_we high, or state CLEAR
overflow  out  1  sticky: at least one on-screen pixel dropped
clip_cnt  out  16  count of off-screen pixels dropped, saturating at 0xFFFF
clear_done  out  1  one-cycle pulse when clear sweep completes

Behaviour:
- Reset (rst low, asynchronous): state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, overflow=0, clip_cnt=0, clear_done=0. An in-flight write is abandoned; mem_we drops immediately.
- Input stage, evaluated every cycle with plot=1:
  - x>=H_RES or y>=V_RES: drop the pixel; clip_cnt+1 (saturating). Clipped pixels never set overflow.
  - FIFO full and no pop this cycle: drop the pixel; set overflow.
  - Otherwise: push {x,y,color}. When full, a push with a simultaneous pop is accepted.
- overflow clears on ovf_clr. If ovf_clr and a new drop occur in the same cycle, overflow stays 1.
- Output stage: one holding register driving mem_we/mem_addr/mem_wdata.
  - Loads when empty or completing a handshake this cycle, FIFO non-empty, and state IDLE.
  - mem_addr = y*H_RES + x, computed from the FIFO head at load; arithmetic is unsigned, truncated to ADDR_W.
  - Address, data and we are held stable while mem_we=1 and mem_ready=0.
  - Back-to-back handshakes sustain one write per clock.
- Latency: with FIFO empty, output idle and mem_ready=1, a plot in cycle N gives mem_we=1 with the correct address in cycle N+2.
- FSM states:
  - IDLE: normal drain. On clear_req, latch clear_color and go to CLEAR. No write may start from the FIFO in the cycle clear_req is seen.
  - CLEAR: first finish any in-flight FIFO write. Then write clear_color to addresses 0..H_RES*V_RES-1 in increasing order, one per handshake, using the same output register and hold rules. FIFO does not pop; pushes, clipping and overflow continue. After the handshake at the last address: pulse clear_done for 1 cycle and return to IDLE. FIFO drain resumes the next cycle.
- clear_req while in CLEAR is ignored.
- Simultaneous clear_req and plot: the pixel is pushed normally and written after the sweep.
- Reset mid-clear: the sweep is abandoned with no clear_done.

Test Plan:
- Single pixel: plot x=3,y=2,color=5 with mem_ready=1 -> exactly 2 cycles later mem_we=1, mem_addr=1283, mem_wdata=5 for one cycle; busy returns to 0.
- Burst with stall: 8 consecutive plots (x=0..7, y=0) while mem_ready=0 for 20 cycles -> mem_we held at addr 0 throughout. The 8th pixel is accepted (7 in FIFO, 1 in output register), no overflow. After release: addresses 0..7 in order, one per cycle.
- Overflow: 12 consecutive plots with mem_ready=0 -> pixels 10..12 dropped, overflow=1. ovf_clr pulse -> overflow=0.
- Clipping: plots at (640,0), (0,480), (2047,2047), (639,479) -> only addr 307199 written; clip_cnt=3; overflow=0.
- Clear: clear_req with clear_color=0xA, then plots during the sweep -> 307200 writes of 0xA at addresses 0..307199. clear_done pulses once, then the buffered plots are written.
- Reset: drop rst mid-burst with mem_we=1 -> mem_we=0 asynchronously. After release, all outputs are at reset values and no stale write is issued.

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel stream consumer: clips off-screen pixels, buffers the rest in a FIFO and writes
// them to a stalling framebuffer port; also runs a full-frame clear sweep on request.
module pixel_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 4,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               plot,
  input  logic [10:0]        x,
  input  logic [10:0]        y,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  input  logic               ovf_clr,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               overflow,
  output logic [15:0]        clip_cnt,
  output logic               clear_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 22 + COLOR_W;
  localparam logic [10:0]       H_LIM     = 11'(H_RES);
  localparam logic [10:0]       V_LIM     = 11'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [PW:0]       FULL_CNT  = (PW + 1)'(DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [EW-1:0]      fifo_q [DEPTH];
  logic [EW-1:0]      fifo_d [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]        count_q, count_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        clip_cnt_q, clip_cnt_d;
  logic               clear_done_q, clear_done_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               last_ld_q, last_ld_d;

  logic [10:0]        head_x_s, head_y_s;
  logic [COLOR_W-1:0] head_c_s;
  logic [ADDR_W-1:0]  lin_s;
  logic hs_s, free_s, empty_s, full_s, clip_s, pop_s, push_s, drop_s;
  logic clr_ld_s, clr_start_s, done_s;

  assign {head_x_s, head_y_s, head_c_s} = fifo_q[rptr_q];
  assign lin_s    = ADDR_W'(head_y_s) * ADDR_W'(H_RES) + ADDR_W'(head_x_s);
  assign hs_s     = mem_we_q & mem_ready;
  assign free_s   = ~mem_we_q | hs_s;
  assign empty_s  = (count_q == '0);
  assign full_s   = (count_q == FULL_CNT);
  assign clip_s   = plot & ((x >= H_LIM) | (y >= V_LIM));
  // FIFO never feeds the output while a clear is pending or running
  assign pop_s    = free_s & ~empty_s & (state_q == S_IDLE) & ~clear_req;
  assign push_s   = plot & ~clip_s & (~full_s | pop_s);
  assign drop_s   = plot & ~clip_s & full_s & ~pop_s;
  assign clr_ld_s = free_s & (state_q == S_CLEAR) & ~last_ld_q;
  assign clr_start_s = (state_q == S_IDLE) & clear_req;

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      clip_cnt_q   <= 16'h0000;
      clear_done_q <= 1'b0;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      last_ld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      clip_cnt_q   <= clip_cnt_d;
      clear_done_q <= clear_done_d;
      clr_addr_q   <= clr_addr_d;
      clr_color_q  <= clr_color_d;
      last_ld_q    <= last_ld_d;
    end
  end

  // Next-state logic; the sweep ends on the handshake of its last address
  always_comb begin
    state_d = state_q;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_req) state_d = S_CLEAR;
        else           state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (hs_s && last_ld_q) begin
          state_d = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: FIFO, holding register, sweep counter, flags
  always_comb begin
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    clr_addr_d   = clr_addr_q;
    clr_color_d  = clr_color_q;
    last_ld_d    = last_ld_q;
    clear_done_d = done_s;

    if (push_s) begin
      fifo_d[wptr_q] = {x, y, color};
      wptr_d         = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d      = rptr_q + PW'(1);
      mem_we_d    = 1'b1;
      mem_addr_d  = lin_s;
      mem_wdata_d = head_c_s;
    end else if (clr_ld_s) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_addr_q;
      mem_wdata_d = clr_color_q;
      clr_addr_d  = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == LAST_ADDR) last_ld_d = 1'b1;
      else                         last_ld_d = last_ld_q;
    end else if (hs_s) begin
      mem_we_d = 1'b0;
    end else begin
      mem_we_d = mem_we_q;
    end

    if (clr_start_s) begin
      clr_color_d = clear_color;
      clr_addr_d  = '0;
      last_ld_d   = 1'b0;
    end else begin
      clr_color_d = clr_color_q;
    end

    count_d = count_q + (PW + 1)'(push_s) - (PW + 1)'(pop_s);

    // A drop in the same cycle as ovf_clr wins
    if (drop_s)       overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else              overflow_d = overflow_q;

    if (clip_s && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
    else                                    clip_cnt_d = clip_cnt_q;

    busy_d = (count_d != '0) | mem_we_d | (state_d == S_CLEAR);
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign clip_cnt   = clip_cnt_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: full-size instance for addressing, stalls, overflow,
// clipping and reset; a small-frame instance for the complete clear sweep.
module tb_pixel_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic plot, clear_req, ovf_clr, mem_ready;
  logic [10:0] x, y;
  logic [3:0] color, clear_color;
  logic mem_we, busy, overflow, clear_done;
  logic [18:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [15:0] clip_cnt;

  logic s_plot, s_clear_req, s_ovf_clr, s_ready;
  logic [10:0] s_x, s_y;
  logic [3:0] s_color, s_clear_color;
  logic s_we, s_busy, s_overflow, s_clear_done;
  logic [5:0] s_addr;
  logic [3:0] s_wdata;
  logic [15:0] s_clip_cnt;

  pixel_writer u_dut (
    .clk(clk), .rst(rst), .plot(plot), .x(x), .y(y), .color(color),
    .clear_req(clear_req), .clear_color(clear_color), .ovf_clr(ovf_clr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .overflow(overflow), .clip_cnt(clip_cnt), .clear_done(clear_done)
  );

  pixel_writer #(.H_RES(12), .V_RES(5), .ADDR_W(6), .COLOR_W(4), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .plot(s_plot), .x(s_x), .y(s_y), .color(s_color),
    .clear_req(s_clear_req), .clear_color(s_clear_color), .ovf_clr(s_ovf_clr),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_ready(s_ready),
    .busy(s_busy), .overflow(s_overflow), .clip_cnt(s_clip_cnt), .clear_done(s_clear_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [31:0] exp_a[$];
  logic [3:0]  exp_d[$];
  logic [31:0] s_exp_a[$];
  logic [3:0]  s_exp_d[$];

  typedef struct {
    logic [10:0] vx;
    logic [10:0] vy;
    logic [3:0]  vc;
    bit          clip;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the full-size instance: every handshake must match the queue head
  always @(negedge clk) begin : mon_big
    logic [31:0] ea;
    logic [3:0]  ed;
    if (rst && mem_we && mem_ready) begin
      if (exp_a.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        ea = exp_a.pop_front();
        ed = exp_d.pop_front();
        check("wr_addr", 32'(mem_addr), ea);
        check("wr_data", 32'(mem_wdata), 32'(ed));
      end
    end
  end

  // Scoreboard for the small-frame instance, plus clear_done pulse counter
  always @(negedge clk) begin : mon_small
    logic [31:0] ea;
    logic [3:0]  ed;
    if (rst && s_clear_done) n_done++;
    if (rst && s_we && s_ready) begin
      if (s_exp_a.size() == 0) begin
        check("s_unexpected_write", 32'(s_addr), 32'hFFFF_FFFF);
      end else begin
        ea = s_exp_a.pop_front();
        ed = s_exp_d.pop_front();
        check("s_wr_addr", 32'(s_addr), ea);
        check("s_wr_data", 32'(s_wdata), 32'(ed));
      end
    end
  end

  task automatic plot_px(input int px, input int py, input int pc);
    plot  = 1'b1;
    x     = 11'(px);
    y     = 11'(py);
    color = 4'(pc);
    tick();
    plot  = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int k = 0;
    while ((exp_a.size() != 0 || busy) && k < max) begin
      tick();
      k++;
    end
    check(name, 32'(k < max), 32'd1);
  endtask

  initial begin
    tbl[0] = '{11'd3,    11'd2,    4'd5, 1'b0, 32'd1283};
    tbl[1] = '{11'd640,  11'd0,    4'd1, 1'b1, 32'd0};
    tbl[2] = '{11'd0,    11'd480,  4'd2, 1'b1, 32'd0};
    tbl[3] = '{11'd2047, 11'd2047, 4'd3, 1'b1, 32'd0};
    tbl[4] = '{11'd639,  11'd479,  4'd9, 1'b0, 32'd307199};
    tbl[5] = '{11'd639,  11'd0,    4'd6, 1'b0, 32'd639};
    tbl[6] = '{11'd0,    11'd1,    4'd7, 1'b0, 32'd640};
    tbl[7] = '{11'd0,    11'd0,    4'd8, 1'b0, 32'd0};

    plot = 1'b0; clear_req = 1'b0; ovf_clr = 1'b0; mem_ready = 1'b1;
    x = '0; y = '0; color = '0; clear_color = '0;
    s_plot = 1'b0; s_clear_req = 1'b0; s_ovf_clr = 1'b0; s_ready = 1'b1;
    s_x = '0; s_y = '0; s_color = '0; s_clear_color = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_clip", 32'(clip_cnt), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Single pixel: write appears exactly two cycles after the plot
    exp_a.push_back(32'd1283); exp_d.push_back(4'd5);
    plot_px(3, 2, 5);
    check("lat_n1_we", 32'(mem_we), 32'd0);
    tick();
    check("lat_n2_we", 32'(mem_we), 32'd1);
    check("lat_n2_addr", 32'(mem_addr), 32'd1283);
    check("lat_n2_data", 32'(mem_wdata), 32'd5);
    tick();
    check("lat_n3_we", 32'(mem_we), 32'd0);
    check("lat_busy", 32'(busy), 32'd0);

    // Table of plots, one per clock, including clip boundaries
    begin
      int nclip = 0;
      for (int i = 0; i < 8; i++) begin
        if (tbl[i].clip) nclip++;
        else begin
          exp_a.push_back(tbl[i].addr);
          exp_d.push_back(tbl[i].vc);
        end
        plot_px(int'(tbl[i].vx), int'(tbl[i].vy), int'(tbl[i].vc));
      end
      drain("tbl_drain", 40);
      check("tbl_clip_cnt", 32'(clip_cnt), 32'(nclip));
      check("tbl_ovf", 32'(overflow), 32'd0);
    end

    // Burst of 8 under stall: head held at address 0, no overflow, then one write per clock
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back(32'(i)); exp_d.push_back(4'(i + 1));
      plot_px(i, 0, i + 1);
    end
    for (int i = 0; i < 12; i++) begin
      check("stall_we", 32'(mem_we), 32'd1);
      check("stall_addr", 32'(mem_addr), 32'd0);
      tick();
    end
    check("burst_ovf", 32'(overflow), 32'd0);
    mem_ready = 1'b1;
    repeat (8) tick();
    check("burst_b2b_left", 32'(exp_a.size()), 32'd0);
    check("burst_we_off", 32'(mem_we), 32'd0);
    drain("burst_drain", 20);

    // Overflow: 12 plots under stall, last three dropped
    mem_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 9) begin
        exp_a.push_back(32'(650 + i)); exp_d.push_back(4'(i));
      end
      plot_px(10 + i, 1, i);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    plot_px(30, 1, 1);
    check("ovf_clr_with_drop", 32'(overflow), 32'd1);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    mem_ready = 1'b1;
    drain("ovf_drain", 40);

    // Clear sweep on the small frame (12x5), with a pending write, plots and a stray clear_req
    s_ready = 1'b0;
    s_exp_a.push_back(32'd13); s_exp_d.push_back(4'd3);
    s_plot = 1'b1; s_x = 11'd1; s_y = 11'd1; s_color = 4'd3;
    tick();
    s_plot = 1'b0;
    tick();
    check("s_inflight_we", 32'(s_we), 32'd1);
    for (int a = 0; a < 60; a++) begin
      s_exp_a.push_back(32'(a)); s_exp_d.push_back(4'hA);
    end
    s_exp_a.push_back(32'd2); s_exp_d.push_back(4'd7);
    s_clear_req = 1'b1; s_clear_color = 4'hA;
    s_plot = 1'b1; s_x = 11'd2; s_y = 11'd0; s_color = 4'd7;
    tick();
    s_clear_req = 1'b0; s_plot = 1'b0;
    tick();
    s_exp_a.push_back(32'd59); s_exp_d.push_back(4'd1);
    s_clear_req = 1'b1; s_clear_color = 4'h5;
    s_plot = 1'b1; s_x = 11'd11; s_y = 11'd4; s_color = 4'd1;
    tick();
    s_clear_req = 1'b0;
    s_x = 11'd12; s_y = 11'd0;
    tick();
    s_plot = 1'b0;
    begin
      int k = 0;
      while ((s_exp_a.size() != 0 || s_busy) && k < 600) begin
        s_ready = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      check("s_clear_drain", 32'(k < 600), 32'd1);
    end
    s_ready = 1'b1;
    check("s_clear_done_cnt", 32'(n_done), 32'd1);
    check("s_clip_cnt", 32'(s_clip_cnt), 32'd1);
    check("s_ovf", 32'(s_overflow), 32'd0);

    // Asynchronous reset with a write held on the port
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) plot_px(100 + i, 3, 2);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_data", 32'(mem_wdata), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_clip", 32'(clip_cnt), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    exp_a.delete(); exp_d.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_we", 32'(mem_we), 32'd0);
    end
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
